// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for the sequential restoring divider.
interface seq_divider_if #(
  parameter int DW = 8,
  parameter int VW = 4
);
  logic          ena;
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic          div_by_zero;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;

  modport master (
    output ena, start, dividend, divisor,
    input  busy, done, div_by_zero, quotient, remainder
  );

  modport slave (
    input  ena, start, dividend, divisor,
    output busy, done, div_by_zero, quotient, remainder
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring divider: one dividend bit per cycle, MSB first, DW cycles per result.
// Divide-by-zero short-circuits straight to DONE with an all-ones quotient.
module seq_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input logic         clk,
  input logic         rst_n,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(DW + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic [DW-1:0] dvd_work;
  logic [DW-1:0] quo_work;
  logic [VW-1:0] dsr_work;
  logic [VW:0]   partial;
  logic [DW-1:0] quotient_q;
  logic [VW-1:0] remainder_q;
  logic          div_by_zero_q;

  logic [VW:0]   shifted;
  logic [VW:0]   trial;
  logic          take;
  logic          last;

  // One restoring step; the extra partial bit keeps the shifted value from overflowing.
  always_comb begin
    shifted = {partial[VW-1:0], dvd_work[DW-1]};
    take    = (shifted >= {1'b0, dsr_work});
    trial   = take ? (shifted - {1'b0, dsr_work}) : shifted;
    last    = (count == CW'(DW - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      count         <= '0;
      dvd_work      <= '0;
      quo_work      <= '0;
      dsr_work      <= '0;
      partial       <= '0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ena && bus.start) begin
            dvd_work <= bus.dividend;
            dsr_work <= bus.divisor;
            partial  <= '0;
            quo_work <= '0;
            count    <= '0;
            if (bus.divisor == '0) begin
              quotient_q    <= '1;
              remainder_q   <= '0;
              div_by_zero_q <= 1'b1;
              state         <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          dvd_work <= dvd_work << 1;
          partial  <= trial;
          quo_work <= {quo_work[DW-2:0], take};
          if (last) begin
            quotient_q    <= {quo_work[DW-2:0], take};
            remainder_q   <= trial[VW-1:0];
            div_by_zero_q <= 1'b0;
            state         <= DONE;
          end else begin
            count <= count + CW'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = (state == RUN);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = div_by_zero_q;
endmodule
